dr32e_prefetch_buffer: RTL and testbench

DR32E_PREFETCH_BUFFER -- requirements
Module: dr32e_prefetch_buffer

---
 rtl/dr32e_pkg.sv | 23 ++
 rtl/dr32e_prefetch_buffer_if.sv | 30 +++
 rtl/dr32e_fetch_fifo.sv | 66 ++++++
 rtl/dr32e_prefetch_buffer.sv | 123 ++++++++++++
 tb/tb_dr32e_prefetch_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dr32e_pkg.sv
// Shared types for the DR32E fetch path: FIFO entry layout, request FSM states,
// and the counter width used for occupancy and outstanding tracking.
package dr32e_pkg;

    // Wide enough for DEPTH (<=4) plus NUM_REQS (<=2) summed together.
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dr32e_prefetch_buffer_if.sv
// Instruction memory bus between the prefetch buffer (master) and memory (slave):
// request/grant address phase followed by in-order rvalid responses.
interface dr32e_prefetch_buffer_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );

endinterface

// File: rtl/dr32e_fetch_fifo.sv
// Circular FIFO of fetched instruction entries; flush empties it and takes
// priority over any push or pop in the same cycle.
module dr32e_fetch_fifo
    import dr32e_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dr32e_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches, tracks in-flight
// requests, drops responses made stale by a branch, and buffers the rest for ID.
module dr32e_prefetch_buffer
    import dr32e_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned NUM_REQS  = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    branch_i,
    input  logic [31:0]             branch_addr_i,
    dr32e_prefetch_buffer_if.master instr_bus,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [31:0]             instr_rdata_id_o,
    output logic [31:0]             instr_rdata_alu_id_o,
    output logic [31:0]             instr_pc_id_o,
    output logic                    instr_fetch_err_o,
    output logic                    instr_first_cycle_id_o,
    output logic                    busy_o
);

    fetch_state_t     r_state;
    logic [31:0]      r_fetch_addr;
    logic [31:0]      r_rsp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic             r_held;

    logic             w_acc;
    logic             w_rvalid;
    logic             w_push;
    logic             w_pop;
    logic             w_can_req;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_out_nxt;
    logic [CNT_W-1:0] w_occ_nxt;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;

    assign w_acc        = instr_bus.instr_req && instr_bus.instr_gnt;
    // A response with nothing in flight is stray (e.g. from before a reset).
    assign w_rvalid     = instr_bus.instr_rvalid && (r_outstanding != '0);
    assign w_push       = w_rvalid && !branch_i && (r_discard == '0);
    assign w_pop        = valid_o && ready_i;
    assign w_push_entry = '{rdata: instr_bus.instr_rdata, pc: r_rsp_pc, err: instr_bus.instr_err};

    assign w_out_nxt = r_outstanding + CNT_W'(w_acc) - CNT_W'(w_rvalid);
    assign w_occ_nxt = branch_i ? '0 : (w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop));
    assign w_can_req = req_i && (w_out_nxt < CNT_W'(NUM_REQS))
                       && ((w_occ_nxt + w_out_nxt) < CNT_W'(DEPTH));

    dr32e_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (branch_i),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .head_o      (w_head),
        .count_o     (w_fifo_count)
    );

    // Responses are in order and every pre-branch one is discarded, so the pc of
    // the next kept response is simply the branch target advanced per kept word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_fetch_addr  <= BOOT_ADDR;
            r_rsp_pc      <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_held        <= 1'b0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (branch_i) begin
                r_discard    <= w_out_nxt;
                r_fetch_addr <= word_align(branch_addr_i);
                r_rsp_pc     <= word_align(branch_addr_i);
            end else begin
                if (w_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - CNT_W'(1);
                end
                if (w_acc) begin
                    r_fetch_addr <= r_fetch_addr + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
            end
            r_held <= valid_o && !w_pop && !branch_i;
            case (r_state)
                S_IDLE:  if (w_can_req) r_state <= S_REQ;
                S_REQ:   if (w_acc && !w_can_req) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_bus.instr_req  = (r_state == S_REQ);
    assign instr_bus.instr_addr = r_fetch_addr;

    assign valid_o                = !w_fifo_empty;
    assign instr_rdata_id_o       = valid_o ? w_head.rdata : '0;
    assign instr_rdata_alu_id_o   = valid_o ? w_head.rdata : '0;
    assign instr_pc_id_o          = valid_o ? w_head.pc : '0;
    assign instr_fetch_err_o      = valid_o && w_head.err;
    assign instr_first_cycle_id_o = valid_o && !r_held;
    assign busy_o                 = (r_outstanding != '0) || instr_bus.instr_req;

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_dr32e_prefetch_buffer.sv
// Scoreboard bench for dr32e_prefetch_buffer: a memory model answers grants in
// order and queues the entries ID should receive; pops are checked against it.
module tb_dr32e_prefetch_buffer;
    import dr32e_pkg::*;

    localparam int unsigned DEPTH_P = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] instr_rdata_alu_id_o;
    logic [31:0] instr_pc_id_o;
    logic        instr_fetch_err_o;
    logic        instr_first_cycle_id_o;
    logic        busy_o;

    dr32e_prefetch_buffer_if bus ();

    dr32e_prefetch_buffer #(
        .DEPTH     (DEPTH_P),
        .NUM_REQS  (2),
        .BOOT_ADDR (32'h0000_0080)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .req_i                  (req_i),
        .branch_i               (branch_i),
        .branch_addr_i          (branch_addr_i),
        .instr_bus              (bus),
        .valid_o                (valid_o),
        .ready_i                (ready_i),
        .instr_rdata_id_o       (instr_rdata_id_o),
        .instr_rdata_alu_id_o   (instr_rdata_alu_id_o),
        .instr_pc_id_o          (instr_pc_id_o),
        .instr_fetch_err_o      (instr_fetch_err_o),
        .instr_first_cycle_id_o (instr_first_cycle_id_o),
        .busy_o                 (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int unsigned cyc;
        bit          disc;
    } pend_t;

    pend_t        pend_q[$];
    fetch_entry_t exp_q[$];
    fetch_entry_t pop_log[$];
    logic [31:0]  acc_log[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc;
    int          first_acc_cyc;
    int          first_valid_cyc;
    int unsigned lat;
    bit          c_req, c_ready, c_gnt, c_br;
    logic [31:0] c_br_addr;
    logic [31:0] err_addr;
    bit          held;
    bit          s_valid, s_first;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic clear_model();
        pend_q.delete();
        exp_q.delete();
        pop_log.delete();
        acc_log.delete();
        cyc             = 0;
        held            = 1'b0;
        s_valid         = 1'b0;
        s_first         = 1'b0;
        first_acc_cyc   = -1;
        first_valid_cyc = -1;
        c_req           = 1'b1;
        c_ready         = 1'b1;
        c_gnt           = 1'b1;
        c_br            = 1'b0;
        c_br_addr       = '0;
        lat             = 1;
        err_addr        = 32'h0000_0001;
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        req_i            = 1'b0;
        ready_i          = 1'b0;
        branch_i         = 1'b0;
        branch_addr_i    = '0;
        bus.instr_gnt    = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = '0;
        bus.instr_err    = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_model();
    endtask

    // One cycle: sample/check at the negedge, drive inputs, advance to next negedge.
    task automatic step();
        fetch_entry_t e;
        pend_t        p;
        bit           acc;
        bit           is_err;
        s_valid = valid_o;
        s_first = instr_first_cycle_id_o;
        chk("valid", valid_o, exp_q.size() != 0);
        if (!bus.instr_req) chk("busy", busy_o, pend_q.size() != 0);
        if (valid_o) chk("first_cycle", instr_first_cycle_id_o, !held);
        if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;

        req_i         = c_req;
        ready_i       = c_ready;
        branch_i      = c_br;
        branch_addr_i = c_br_addr;

        if (valid_o && ready_i && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pop_pc", instr_pc_id_o, e.pc);
            chk("pop_err", instr_fetch_err_o, e.err);
            if (!e.err) begin
                chk("pop_rdata", instr_rdata_id_o, e.rdata);
                chk("pop_rdata_alu", instr_rdata_alu_id_o, e.rdata);
            end
            pop_log.push_back('{rdata: instr_rdata_id_o, pc: instr_pc_id_o, err: instr_fetch_err_o});
        end
        held = valid_o && !ready_i && !c_br;

        bus.instr_gnt    = c_gnt;
        acc              = bus.instr_req && c_gnt;
        bus.instr_rvalid = 1'b0;
        bus.instr_err    = 1'b0;
        bus.instr_rdata  = '0;
        if (pend_q.size() != 0 && cyc >= pend_q[0].cyc + lat) begin
            p                = pend_q.pop_front();
            is_err           = (p.addr == err_addr);
            bus.instr_rvalid = 1'b1;
            bus.instr_err    = is_err;
            bus.instr_rdata  = is_err ? 32'hDEAD_BEEF : mem_data(p.addr);
            if (!p.disc && !c_br) begin
                chk("no_overflow", exp_q.size() < DEPTH_P, 1);
                exp_q.push_back('{rdata: mem_data(p.addr), pc: p.addr, err: is_err});
            end
        end
        if (acc) begin
            pend_q.push_back('{addr: bus.instr_addr, cyc: cyc, disc: c_br});
            acc_log.push_back(bus.instr_addr);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (c_br) begin
            foreach (pend_q[i]) pend_q[i].disc = 1'b1;
            exp_q.delete();
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned br_acc, br_pop;
        bit f0, f1, f2, f3;

        // Reset state
        do_reset();
        chk("rst_req", bus.instr_req, 0);
        chk("rst_addr", bus.instr_addr, 32'h0000_0080);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_first", instr_first_cycle_id_o, 0);
        chk("rst_err", instr_fetch_err_o, 0);
        chk("rst_rdata", instr_rdata_id_o, 0);
        chk("rst_pc", instr_pc_id_o, 0);

        // Streaming fetch, grant always, 1-cycle response
        repeat (12) step();
        chk("seq_nacc", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            chk("seq_addr0", acc_log[0], 32'h80);
            chk("seq_addr1", acc_log[1], 32'h84);
            chk("seq_addr2", acc_log[2], 32'h88);
        end
        chk("seq_latency", first_valid_cyc - first_acc_cyc, 2);

        // ID stalled: buffer fills after DEPTH requests
        do_reset();
        c_ready = 1'b0;
        repeat (10) step();
        chk("stall_nacc", acc_log.size(), 3);
        chk("stall_req", bus.instr_req, 0);
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        for (int k = 0; k < 6 && acc_log.size() < 4; k++) step();
        chk("resume_nacc", acc_log.size(), 4);
        if (acc_log.size() >= 4) chk("resume_addr", acc_log[3], 32'h8C);

        // Grant withheld: address and request held
        do_reset();
        c_gnt = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("nogrant_addr", bus.instr_addr, 32'h80);
            chk("nogrant_req", bus.instr_req, 1);
            step();
        end
        c_gnt = 1'b1;
        repeat (6) step();
        chk("nogrant_first_acc", acc_log.size() != 0 ? acc_log[0] : 32'hFFFF_FFFF, 32'h80);

        // Branch with two requests outstanding
        do_reset();
        lat = 2;
        for (int k = 0; k < 10 && acc_log.size() < 2; k++) step();
        chk("br_outstanding", pend_q.size(), 2);
        c_br      = 1'b1;
        c_br_addr = 32'h0000_1003;
        step();
        c_br   = 1'b0;
        br_acc = acc_log.size();
        repeat (12) step();
        chk("br_nacc", acc_log.size() > br_acc, 1);
        if (acc_log.size() > br_acc) chk("br_next_addr", acc_log[br_acc], 32'h1000);
        chk("br_npop", pop_log.size() != 0, 1);
        if (pop_log.size() != 0) chk("br_first_pc", pop_log[0].pc, 32'h1000);

        // Bus error on second response
        do_reset();
        err_addr = 32'h84;
        repeat (10) step();
        chk("err_npop", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            chk("err_pc1", pop_log[1].pc, 32'h84);
            chk("err_flag1", pop_log[1].err, 1);
            chk("err_pc2", pop_log[2].pc, 32'h88);
            chk("err_flag2", pop_log[2].err, 0);
        end

        // First-cycle flag across a held head and a pop
        do_reset();
        c_ready = 1'b0;
        for (int k = 0; k < 10 && !s_valid; k++) step();
        f0 = s_first;
        step();
        f1 = s_first;
        c_ready = 1'b1;
        step();
        f2 = s_first;
        c_ready = 1'b0;
        step();
        f3 = s_first;
        chk("first_seq", {28'd0, f0, f1, f2, f3}, 32'b1001);

        // Branch with a grant in the same cycle, address wrap at 2^32
        do_reset();
        repeat (4) step();
        c_br      = 1'b1;
        c_br_addr = 32'hFFFF_FFFA;
        step();
        c_br   = 1'b0;
        br_acc = acc_log.size();
        br_pop = pop_log.size();
        repeat (10) step();
        chk("wrap_nacc", acc_log.size() >= br_acc + 3, 1);
        if (acc_log.size() >= br_acc + 3) begin
            chk("wrap_addr0", acc_log[br_acc], 32'hFFFF_FFF8);
            chk("wrap_addr1", acc_log[br_acc + 1], 32'hFFFF_FFFC);
            chk("wrap_addr2", acc_log[br_acc + 2], 32'h0000_0000);
        end
        if (pop_log.size() > br_pop) chk("wrap_first_pc", pop_log[br_pop].pc, 32'hFFFF_FFF8);
        else chk("wrap_npop", pop_log.size() - br_pop, 1);

        // Reset mid-transaction, stray rvalid right after
        do_reset();
        lat = 2;
        repeat (3) step();
        rst_i            = 1'b1;
        req_i            = 1'b0;
        bus.instr_gnt    = 1'b0;
        bus.instr_rvalid = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i            = 1'b0;
        bus.instr_rvalid = 1'b1;
        bus.instr_rdata  = 32'h1234_5678;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.instr_rvalid = 1'b0;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_addr", bus.instr_addr, 32'h80);
        clear_model();
        repeat (8) step();
        chk("midrst_npop", pop_log.size() != 0, 1);
        if (pop_log.size() != 0) chk("midrst_first_pc", pop_log[0].pc, 32'h80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
